// File: rtl/cra_launcher.sv
// Loads a kernel argument table into a CRA slave over Avalon-MM, writes the start bit, then times the run.
// Optional watchdog: define CRA_LAUNCHER_WATCHDOG_EN to end a run after TIMEOUT_CYCLES.
module cra_launcher #(
   parameter int unsigned ARG_NUM        = 16,
   parameter int unsigned ARG_BASE_ADDR  = 5,
   parameter int unsigned ARG_HALF_OFS   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arg_wr_en,
   input  logic [$clog2(ARG_NUM)-1:0]   arg_wr_idx,
   input  logic [31:0]                  arg_wr_data,
   input  logic [$clog2(ARG_NUM):0]     arg_cnt,
   input  logic                         launch,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout,
   output logic [31:0]                  cycles,
   output logic [7:0]                   cra_address,
   output logic [63:0]                  cra_writedata,
   output logic [7:0]                   cra_byteenable,
   output logic                         cra_write,
   output logic                         cra_read,
   input  logic                         cra_waitrequest,
   input  logic                         kernel_irq
);

   localparam int unsigned IW    = $clog2(ARG_NUM);
   localparam int unsigned CW    = IW + 1;
   localparam int unsigned HALF0 = 2 * ARG_BASE_ADDR + ARG_HALF_OFS;

   typedef enum logic [2:0] {IDLE, ARG, START, RUN, FIN} state_t;

   state_t        state, state_d;
   logic [IW-1:0] k, k_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [31:0]   cycles_d, cyc_inc, half;
   logic          busy_d, done_d, write_d, accepted, wd_hit;
   logic [7:0]    addr_d, be_d;
   logic [63:0]   data_d;
   logic [31:0]   args [ARG_NUM];

   assign cra_read = 1'b0;
   assign accepted = cra_write && !cra_waitrequest;
   assign cyc_inc  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

`ifdef CRA_LAUNCHER_WATCHDOG_EN
   logic timeout_d;
   assign wd_hit = (cyc_inc >= 32'(TIMEOUT_CYCLES));
`else
   // Keeps the limit parameter referenced when the watchdog is compiled out.
   logic unused_limit;
   assign unused_limit = ^(32'(TIMEOUT_CYCLES));
   assign wd_hit       = 1'b0;
   assign timeout      = 1'b0;
`endif

   // Argument table: host-side writes only while no sequence is running; never reset.
   always_ff @(posedge clk) begin
      if (arg_wr_en && !busy) args[arg_wr_idx] <= arg_wr_data;
   end

   // Next state, counters, and next values of the registered bus outputs.
   always_comb begin
      state_d  = state;
      k_d      = k;
      cnt_d    = cnt;
      cycles_d = cycles;
      done_d   = 1'b0;
`ifdef CRA_LAUNCHER_WATCHDOG_EN
      timeout_d = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (launch) begin
               cnt_d    = (32'(arg_cnt) > ARG_NUM) ? CW'(ARG_NUM) : arg_cnt;
               k_d      = '0;
               cycles_d = '0;
               state_d  = (arg_cnt == '0) ? START : ARG;
            end
         end
         ARG: begin
            if (accepted) begin
               if (CW'(k) + CW'(1) == cnt) state_d = START;
               else                        k_d     = k + IW'(1);
            end
         end
         START: begin
            if (accepted) state_d = RUN;
         end
         RUN: begin
            cycles_d = cyc_inc;
            if (kernel_irq) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else if (wd_hit) begin
               state_d = FIN;
               done_d  = 1'b1;
`ifdef CRA_LAUNCHER_WATCHDOG_EN
               timeout_d = 1'b1;
`endif
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Slot k lives in half-word HALF0+k; odd half-words are the upper 32 bits.
      half    = 32'(HALF0) + 32'(k_d);
      busy_d  = (state_d != IDLE);
      write_d = (state_d == ARG) || (state_d == START);
      addr_d  = '0;
      data_d  = '0;
      be_d    = '0;
      if (state_d == ARG) begin
         addr_d = 8'(half >> 1);
         if (half[0]) begin
            be_d   = 8'hF0;
            data_d = {args[k_d], 32'h0};
         end else begin
            be_d   = 8'h0F;
            data_d = {32'h0, args[k_d]};
         end
      end else if (state_d == START) begin
         data_d = 64'h1;
         be_d   = 8'h0F;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         k              <= '0;
         cnt            <= '0;
         cycles         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         cra_write      <= 1'b0;
         cra_address    <= '0;
         cra_writedata  <= '0;
         cra_byteenable <= '0;
      end else begin
         state          <= state_d;
         k              <= k_d;
         cnt            <= cnt_d;
         cycles         <= cycles_d;
         busy           <= busy_d;
         done           <= done_d;
         cra_write      <= write_d;
         cra_address    <= addr_d;
         cra_writedata  <= data_d;
         cra_byteenable <= be_d;
      end
   end

`ifdef CRA_LAUNCHER_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (rst) timeout <= 1'b0;
      else     timeout <= timeout_d;
   end
`endif

endmodule

// File: tb/tb_cra_launcher.sv
// Directed bench for cra_launcher: table of launch scenarios plus hand sequences for reset, idle irq and watchdog.
module tb_cra_launcher;

   localparam int unsigned ARG_NUM = 16;
   localparam int unsigned IW      = 4;
   localparam int unsigned CW      = 5;
`ifdef CRA_LAUNCHER_WATCHDOG_EN
   localparam int unsigned TO_LIM  = 100;
`else
   localparam int unsigned TO_LIM  = 1000000;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arg_wr_en = 1'b0;
   logic [IW-1:0] arg_wr_idx = '0;
   logic [31:0]   arg_wr_data = '0;
   logic [CW-1:0] arg_cnt = '0;
   logic          launch = 1'b0;
   logic          busy, done, timeout, cra_write, cra_read;
   logic [31:0]   cycles;
   logic [7:0]    cra_address, cra_byteenable;
   logic [63:0]   cra_writedata;
   logic          cra_waitrequest = 1'b0;
   logic          kernel_irq = 1'b0;

   always #5 clk = ~clk;

   cra_launcher #(.ARG_NUM(ARG_NUM), .ARG_BASE_ADDR(5), .ARG_HALF_OFS(1), .TIMEOUT_CYCLES(TO_LIM)) dut (
      .clk(clk), .rst(rst), .arg_wr_en(arg_wr_en), .arg_wr_idx(arg_wr_idx), .arg_wr_data(arg_wr_data),
      .arg_cnt(arg_cnt), .launch(launch), .busy(busy), .done(done), .timeout(timeout), .cycles(cycles),
      .cra_address(cra_address), .cra_writedata(cra_writedata), .cra_byteenable(cra_byteenable),
      .cra_write(cra_write), .cra_read(cra_read), .cra_waitrequest(cra_waitrequest), .kernel_irq(kernel_irq)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hand-computed CRA word address and byte lanes for slots 0..15 (half-word 11+k).
   int          exp_addr [16] = '{5, 6, 6, 7, 7, 8, 8, 9, 9, 10, 10, 11, 11, 12, 12, 13};
   logic [7:0]  exp_be   [16] = '{8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F,
                                  8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
   logic [31:0] slot_val [16];

   typedef struct {
      logic [7:0]  addr;
      logic [63:0] data;
      logic [7:0]  be;
      int          hold;
   } wr_t;

   wr_t         wq[$];
   int          waitn = 0;
   int          stall = 0;
   int          hold = 0;
   logic [7:0]  pa, pb;
   logic [63:0] pd;

   // Slave model: stalls each write waitn cycles, checks it stays stable, logs it on acceptance.
   always @(negedge clk) begin
      if (rst || !cra_write) begin
         cra_waitrequest = 1'b0;
         stall = 0;
         hold = 0;
      end else begin
         if (hold > 0) begin
            check("hold_addr", 64'(cra_address), 64'(pa));
            check("hold_data", cra_writedata, pd);
            check("hold_be", 64'(cra_byteenable), 64'(pb));
         end
         pa = cra_address; pd = cra_writedata; pb = cra_byteenable;
         hold++;
         if (stall < waitn) begin
            cra_waitrequest = 1'b1;
            stall++;
         end else begin
            cra_waitrequest = 1'b0;
            wq.push_back('{cra_address, cra_writedata, cra_byteenable, hold});
            stall = 0;
            hold = 0;
         end
      end
   end

   typedef struct {
      int cnt;
      int waitn;
      int irq;
      int poke;
      int exp_wr;
      int exp_cyc;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v, input string tag);
      int c;
      bit got;
      int nslot;
      logic [63:0] ed;
      waitn = v.waitn;
      wq.delete();
      @(posedge clk); #1;
      arg_cnt = CW'(v.cnt);
      launch = 1'b1;
      @(posedge clk); #1;
      launch = 1'b0;
      check({tag, ":first_write"}, 64'(cra_write), 64'd1);
      check({tag, ":busy"}, 64'(busy), 64'd1);
      check({tag, ":cycles_clr"}, 64'(cycles), 64'd0);
      c = 0;
      got = 1'b0;
      while (!got && c < 400) begin
         if (wq.size() > 0 && wq[$].addr == 8'h0 && wq[$].data == 64'h1) got = 1'b1;
         else begin
            @(posedge clk); #1;
            c++;
         end
      end
      check({tag, ":start_seen"}, 64'(got), 64'd1);
      check({tag, ":start_latency"}, 64'(c), 64'(v.exp_wr * (v.waitn + 1)));
      if (v.poke != 0) begin
         launch = 1'b1;
         arg_cnt = CW'(2);
         arg_wr_en = 1'b1;
         arg_wr_idx = '0;
         arg_wr_data = 32'hDEAD_BEEF;
      end
      for (int i = 1; i < v.irq; i++) begin
         @(posedge clk); #1;
         launch = 1'b0;
         arg_wr_en = 1'b0;
      end
      kernel_irq = 1'b1;
      @(posedge clk); #1;
      kernel_irq = 1'b0;
      launch = 1'b0;
      arg_wr_en = 1'b0;
      check({tag, ":done"}, 64'(done), 64'd1);
      check({tag, ":timeout"}, 64'(timeout), 64'd0);
      check({tag, ":busy_fin"}, 64'(busy), 64'd1);
      check({tag, ":cycles"}, 64'(cycles), 64'(v.exp_cyc));
      @(posedge clk); #1;
      check({tag, ":done_pulse"}, 64'(done), 64'd0);
      check({tag, ":idle"}, 64'(busy), 64'd0);
      check({tag, ":cycles_hold"}, 64'(cycles), 64'(v.exp_cyc));
      @(posedge clk); #1;
      check({tag, ":no_relaunch"}, 64'(cra_write), 64'd0);
      check({tag, ":n_writes"}, 64'(wq.size()), 64'(v.exp_wr));
      nslot = v.exp_wr - 1;
      for (int i = 0; i < nslot && i < wq.size(); i++) begin
         ed = (exp_be[i] == 8'hF0) ? {slot_val[i], 32'h0} : {32'h0, slot_val[i]};
         check($sformatf("%s:w%0d_addr", tag, i), 64'(wq[i].addr), 64'(exp_addr[i]));
         check($sformatf("%s:w%0d_be", tag, i), 64'(wq[i].be), 64'(exp_be[i]));
         check($sformatf("%s:w%0d_data", tag, i), wq[i].data, ed);
         check($sformatf("%s:w%0d_hold", tag, i), 64'(wq[i].hold), 64'(v.waitn + 1));
      end
      if (wq.size() == v.exp_wr) begin
         check({tag, ":start_addr"}, 64'(wq[nslot].addr), 64'd0);
         check({tag, ":start_data"}, wq[nslot].data, 64'h1);
         check({tag, ":start_be"}, 64'(wq[nslot].be), 64'h0F);
         check({tag, ":start_hold"}, 64'(wq[nslot].hold), 64'(v.waitn + 1));
      end
   endtask

   initial begin
      int c;
      //               cnt wait irq poke exp_wr exp_cyc
      vecs[0] = '{  4,  0, 50, 0,  5, 50};
      vecs[1] = '{  4,  3, 10, 1,  5, 10};
      vecs[2] = '{  0,  0,  5, 0,  1,  5};
      vecs[3] = '{ 16,  1,  3, 0, 17,  3};
      vecs[4] = '{ 20,  0,  1, 0, 17,  1};
      vecs[5] = '{  1,  2,  2, 0,  2,  2};
      for (int i = 0; i < 16; i++) slot_val[i] = (i < 4) ? 32'd1 : (32'hC0DE_0000 | 32'(i));

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_write", 64'(cra_write), 64'd0);
      check("rst_cycles", 64'(cycles), 64'd0);
      check("rst_read", 64'(cra_read), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         arg_wr_en = 1'b1;
         arg_wr_idx = IW'(i);
         arg_wr_data = slot_val[i];
         @(posedge clk); #1;
      end
      arg_wr_en = 1'b0;

      kernel_irq = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      kernel_irq = 1'b0;
      check("idle_irq_done", 64'(done), 64'd0);
      check("idle_irq_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of the argument phase, then a full relaunch.
      waitn = 0;
      wq.delete();
      arg_cnt = CW'(4);
      launch = 1'b1;
      @(posedge clk); #1;
      launch = 1'b0;
      c = 0;
      while (wq.size() < 2 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("mid_rst_two_writes", 64'(wq.size()), 64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_write", 64'(cra_write), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_cycles", 64'(cycles), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      run_vec(vecs[0], "relaunch");

`ifdef CRA_LAUNCHER_WATCHDOG_EN
      waitn = 0;
      wq.delete();
      @(posedge clk); #1;
      arg_cnt = '0;
      launch = 1'b1;
      @(posedge clk); #1;
      launch = 1'b0;
      c = 0;
      while (!done && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check("wd_done", 64'(done), 64'd1);
      check("wd_timeout", 64'(timeout), 64'd1);
      check("wd_cycles", 64'(cycles), 64'd100);
      @(posedge clk); #1;
      check("wd_idle", 64'(busy), 64'd0);
      check("wd_timeout_clr", 64'(timeout), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/cra_launcher.md
CRA_LAUNCHER -- requirements
Module: cra_launcher

Interface
REQ-001 Parameter ARG_NUM, default 16: number of 32-bit argument slots in the table.
REQ-002 Parameter ARG_BASE_ADDR, default 5: CRA word address of the first argument half-word.
REQ-003 Parameter ARG_HALF_OFS, default 1: half-word offset of slot 0 (1 = upper half of ARG_BASE_ADDR).
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000: watchdog limit, used only with the watchdog compiled in.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port arg_wr_en, input, 1: write one argument slot.
REQ-008 Port arg_wr_idx, input, $clog2(ARG_NUM): slot index.
REQ-009 Port arg_wr_data, input, 32: slot value.
REQ-010 Port arg_cnt, input, $clog2(ARG_NUM)+1: number of slots to send, sampled on launch.
REQ-011 Port launch, input, 1: single-cycle start request.
REQ-012 Port busy, output, 1: sequence in progress.
REQ-013 Port done, output, 1: one-cycle completion pulse.
REQ-014 Port timeout, output, 1: valid with done; completion was caused by the watchdog.
REQ-015 Port cycles, output, 32: kernel run length of the last launch.
REQ-016 Ports cra_address (8), cra_writedata (64), cra_byteenable (8), cra_write (1), cra_read (1): outputs, Avalon-MM master to the kernel CRA.
REQ-017 Port cra_waitrequest, input, 1: Avalon-MM stall.
REQ-018 Port kernel_irq, input, 1: kernel completion, level.

Function
REQ-019 FSM states: IDLE, ARG, START, RUN, FIN.
REQ-020 IDLE: launch=1 latches arg_cnt, clears slot counter k and cycles, and goes to ARG, or to START when arg_cnt=0.
REQ-021 ARG: for slot k, h = 2*ARG_BASE_ADDR + ARG_HALF_OFS + k; cra_address = h>>1.
REQ-022 ARG: for odd h, byteenable = 8'hF0 and writedata = {arg,32'h0}; for even h, byteenable = 8'h0F and writedata = {32'h0,arg}.
REQ-023 A write is accepted on a cycle with cra_write=1 and cra_waitrequest=0; address, data and byteenable hold stable until acceptance.
REQ-024 Accepted write in ARG increments k; after slot arg_cnt-1 is accepted, the FSM goes to START with no idle cycle.
REQ-025 START: write address 0, writedata 64'h1, byteenable 8'h0F; on acceptance go to RUN.
REQ-026 RUN: cycles increments each cycle, saturating at 32'hFFFFFFFF; kernel_irq=1 goes to FIN.
REQ-027 FIN: done=1 for one cycle, then IDLE; cycles holds its value until the next launch.
REQ-028 busy = 1 in all states except IDLE.
REQ-029 cra_read is 0 at all times.
REQ-030 Table accepts arg_wr_en only while busy=0; writes while busy are dropped.
REQ-031 launch while busy=1 is ignored.
REQ-032 kernel_irq outside RUN is ignored.
REQ-033 arg_cnt > ARG_NUM is clamped to ARG_NUM.

Reset
REQ-034 rst=1 forces IDLE on the next clk edge, including mid-sequence.
REQ-035 On that edge, cra_write, busy, done and timeout return to 0 and cycles returns to 0.
REQ-036 Table contents are not reset.
REQ-037 A write pending under waitrequest is abandoned on reset.

Configuration
REQ-038 Macro CRA_LAUNCHER_WATCHDOG_EN defined: in RUN, when cycles reaches TIMEOUT_CYCLES, go to FIN with timeout=1 during done.
REQ-039 kernel_irq and the watchdog limit in the same cycle: timeout=0, kernel_irq takes priority.
REQ-040 Macro CRA_LAUNCHER_WATCHDOG_EN undefined: timeout is constant 0 and RUN waits for kernel_irq indefinitely.

Verification
REQ-041 Defaults, slots 0..3 = 1,1,1,1, arg_cnt=4, waitrequest=0, irq 50 cycles after the start write -> writes (5,F0), (6,0F), (6,F0), (7,0F), then (0, 64'h1, 0F); done=1; cycles=50.
REQ-042 waitrequest held high 3 cycles on each write -> each write held stable for 4 cycles; no write lost or duplicated.
REQ-043 arg_cnt=0 -> first cra_write goes to address 0 on the cycle after launch.
REQ-044 rst pulsed during ARG after 2 accepted writes -> cra_write=0 and busy=0 on the next cycle; relaunch sends all slots from slot 0.
REQ-045 With CRA_LAUNCHER_WATCHDOG_EN, TIMEOUT_CYCLES=100, no irq -> done with timeout=1, cycles=100.
REQ-046 launch and arg_wr_en asserted during RUN -> both ignored; table unchanged.
